two_mode_timer_ctrl: RTL and testbench



---
 rtl/two_mode_timer_ctrl.sv | 117 +++++++++++
 tb/tb_two_mode_timer_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/two_mode_timer_ctrl.sv
// two_mode_timer_ctrl
//   Controller for the two-mode timer. Mode 0 counts up, mode 1 counts down
//   from a preload. Both counts advance once per prescaled tick while the
//   FSM is in RUN. The block also owns the select line of the shared 2-way
//   display mux.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      level; start / resume request
//   stop       level; pause request
//   clear      level; back to IDLE, zero up_count, preload down_count
//   mode_btn   mode toggle, acts on its rising edge while IDLE
//   load_val   countdown preload, captured when clear is high
//   up_count   mode-0 count (mux in1)
//   down_count mode-1 count (mux in2)
//   sel        mux select: 0 = up timer, 1 = down timer
//   running    high only in RUN
//   done       high only in DONE
module two_mode_timer_ctrl #(
  parameter int         TICK_DIV     = 50,
  parameter logic [7:0] LOAD_DEFAULT = 8'd60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       mode_btn,
  input  logic [7:0] load_val,
  output logic [7:0] up_count,
  output logic [7:0] down_count,
  output logic       sel,
  output logic       running,
  output logic       done
);

  localparam int            PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          mode_btn_q;
  logic          rise;
  logic          tick;

  assign rise = mode_btn & ~mode_btn_q;
  // The prescaler only moves in RUN, so tick is qualified by state.
  assign tick = (state == S_RUN) && (presc == PRE_MAX);

  // Status flags are pure decodes of the state register.
  assign running = (state == S_RUN);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sel        <= 1'b0;
      up_count   <= 8'd0;
      down_count <= LOAD_DEFAULT;
      presc      <= '0;
      mode_btn_q <= 1'b0;
    end else begin
      // Edge register tracks the button every cycle, so a rise seen outside
      // IDLE is consumed and never replayed later.
      mode_btn_q <= mode_btn;

      if (clear) begin
        state      <= S_IDLE;
        up_count   <= 8'd0;
        down_count <= load_val;
        presc      <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise) sel <= ~sel;
            // stop outranks start; the start decision uses the current sel.
            if (!stop && start) begin
              presc <= '0;
              // An empty countdown completes immediately, never entering RUN.
              state <= (sel && (down_count == 8'd0)) ? S_DONE : S_RUN;
            end
          end
          S_RUN: begin
            if (stop) begin
              // Freezes the prescaler too, even on a tick cycle.
              state <= S_PAUSE;
            end else if (tick) begin
              presc <= '0;
              if (!sel) begin
                up_count <= up_count + 8'd1;
              end else begin
                down_count <= down_count - 8'd1;
                if (down_count == 8'd1) state <= S_DONE;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          S_PAUSE: begin
            // Resume keeps the frozen prescaler phase.
            if (!stop && start) state <= S_RUN;
          end
          default: ; // DONE holds until clear or rst
        endcase
      end
    end
  end

endmodule

// File: tb/tb_two_mode_timer_ctrl.sv
module tb_two_mode_timer_ctrl;

  localparam int TD = 4;

  logic       clk, rst, clk_en;
  logic       start, stop, clear, mode_btn;
  logic [7:0] load_val;
  logic [7:0] up_count, down_count;
  logic       sel, running, done;

  int total = 0;
  int bad   = 0;

  two_mode_timer_ctrl #(.TICK_DIV(TD), .LOAD_DEFAULT(8'd60)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .mode_btn(mode_btn), .load_val(load_val), .up_count(up_count),
    .down_count(down_count), .sel(sel), .running(running), .done(done)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  // Behavioural reference: phase counter, mode flag and a named status,
  // advanced once per clock from the rules of the timer.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int       m_st;
  int       m_phase;
  bit       m_mode;
  int       m_up, m_down;
  bit       m_btn_prev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = M_IDLE; m_phase = 0; m_mode = 0; m_up = 0; m_down = 60;
      m_btn_prev = 0;
    end else begin
      bit pressed;
      pressed = mode_btn && !m_btn_prev;
      m_btn_prev = mode_btn;
      if (clear) begin
        m_st = M_IDLE; m_up = 0; m_down = load_val; m_phase = 0;
      end else if (m_st == M_IDLE) begin
        bit old_mode;
        old_mode = m_mode;
        if (pressed) m_mode = !m_mode;
        if (!stop && start) begin
          m_phase = 0;
          m_st = (old_mode && m_down == 0) ? M_DONE : M_RUN;
        end
      end else if (m_st == M_RUN) begin
        if (stop) m_st = M_PAUSE;
        else if (m_phase == TD - 1) begin
          m_phase = 0;
          if (!m_mode) m_up = (m_up + 1) % 256;
          else begin
            m_down = m_down - 1;
            if (m_down == 0) m_st = M_DONE;
          end
        end else m_phase = m_phase + 1;
      end else if (m_st == M_PAUSE) begin
        if (!stop && start) m_st = M_RUN;
      end
    end
  end

  // One clock: inputs set at the negedge are sampled by the next posedge,
  // and outputs are read back at the following negedge.
  task automatic cyc(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; stop = 0; clear = 0; mode_btn = 0; load_val = 0;
    clk_en = 1;
    cyc(2);
    total++; if (up_count !== 8'd0 || down_count !== 8'd60 || sel !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_values up=%0d down=%0d sel=%b run=%b done=%b want 0/60/0/0/0", up_count, down_count, sel, running, done);
    end
    rst = 0;
    cyc();
    start = 1; cyc(); start = 0;
    cyc(5);
    total++; if (up_count !== 8'd1 || running !== 1'b1) begin
      bad++; $display("FAIL pre_async up=%0d run=%b want 1/1", up_count, running);
    end
    // Freeze the clock low, then reset: outputs must drop without an edge.
    clk_en = 0;
    #2 rst = 1;
    #1;
    total++; if (up_count !== 8'd0 || down_count !== 8'd60 || sel !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL async_reset up=%0d down=%0d sel=%b run=%b done=%b want 0/60/0/0/0", up_count, down_count, sel, running, done);
    end
    #1 rst = 0;
    clk_en = 1;
    @(negedge clk);
  endtask

  task automatic test_count_up();
    start = 1; cyc(); start = 0;
    total++; if (running !== 1'b1 || up_count !== 8'd0) begin
      bad++; $display("FAIL up_start run=%b up=%0d want 1/0", running, up_count);
    end
    cyc(3);
    total++; if (up_count !== 8'd0) begin
      bad++; $display("FAIL up_before_tick up=%0d want 0", up_count);
    end
    cyc();
    total++; if (up_count !== 8'd1) begin
      bad++; $display("FAIL up_tick1 up=%0d want 1", up_count);
    end
    cyc(4);
    total++; if (up_count !== 8'd2 || down_count !== 8'd60) begin
      bad++; $display("FAIL up_tick2 up=%0d down=%0d want 2/60", up_count, down_count);
    end
    for (int i = 0; i < 1100 && up_count !== 8'd255; i++) cyc();
    total++; if (up_count !== 8'd255) begin
      bad++; $display("FAIL up_reach_255 up=%0d want 255 (cycle budget)", up_count);
    end
    cyc(4);
    total++; if (up_count !== 8'd0 || running !== 1'b1) begin
      bad++; $display("FAIL up_wrap up=%0d run=%b want 0/1", up_count, running);
    end
  endtask

  task automatic test_count_down();
    clear = 1; load_val = 8'd3; cyc(); clear = 0;
    total++; if (down_count !== 8'd3 || up_count !== 8'd0 || running !== 1'b0) begin
      bad++; $display("FAIL dn_clear down=%0d up=%0d run=%b want 3/0/0", down_count, up_count, running);
    end
    mode_btn = 1; cyc(); mode_btn = 0; cyc();
    total++; if (sel !== 1'b1) begin
      bad++; $display("FAIL dn_sel sel=%b want 1", sel);
    end
    start = 1; cyc(); start = 0;
    cyc(3);
    total++; if (down_count !== 8'd3 || running !== 1'b1) begin
      bad++; $display("FAIL dn_before_tick down=%0d run=%b want 3/1", down_count, running);
    end
    cyc();
    total++; if (down_count !== 8'd2) begin
      bad++; $display("FAIL dn_tick1 down=%0d want 2", down_count);
    end
    cyc(4);
    total++; if (down_count !== 8'd1 || done !== 1'b0) begin
      bad++; $display("FAIL dn_tick2 down=%0d done=%b want 1/0", down_count, done);
    end
    cyc(4);
    total++; if (down_count !== 8'd0 || done !== 1'b1 || running !== 1'b0) begin
      bad++; $display("FAIL dn_done down=%0d done=%b run=%b want 0/1/0", down_count, done, running);
    end
    start = 1; cyc(6); start = 0;
    total++; if (done !== 1'b1 || running !== 1'b0 || down_count !== 8'd0 || up_count !== 8'd0) begin
      bad++; $display("FAIL dn_done_hold done=%b run=%b down=%0d up=%0d want 1/0/0/0", done, running, down_count, up_count);
    end
    clear = 1; cyc(); clear = 0;
    total++; if (done !== 1'b0 || running !== 1'b0 || down_count !== 8'd3 || sel !== 1'b1) begin
      bad++; $display("FAIL dn_reclear done=%b run=%b down=%0d sel=%b want 0/0/3/1", done, running, down_count, sel);
    end
  endtask

  task automatic test_pause_resume();
    clear = 1; load_val = 8'd200; cyc(); clear = 0;
    start = 1; cyc(); start = 0;   // prescaler 0
    cyc(2);                        // prescaler 2
    stop = 1; cyc(); stop = 0;     // paused at 2
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++; if (down_count !== 8'd200 || running !== 1'b0) begin
        bad++; $display("FAIL pause_frozen i=%0d down=%0d run=%b want 200/0", i, down_count, running);
      end
    end
    start = 1; cyc(); start = 0;   // RUN, prescaler still 2
    cyc();                         // prescaler 3
    total++; if (down_count !== 8'd200 || running !== 1'b1) begin
      bad++; $display("FAIL resume_pre down=%0d run=%b want 200/1", down_count, running);
    end
    cyc();
    total++; if (down_count !== 8'd199) begin
      bad++; $display("FAIL resume_tick down=%0d want 199", down_count);
    end
    cyc(3);                        // prescaler 3 again
    stop = 1; cyc(); stop = 0;     // tick cycle collides with stop
    total++; if (down_count !== 8'd199 || running !== 1'b0) begin
      bad++; $display("FAIL tick_stop down=%0d run=%b want 199/0", down_count, running);
    end
  endtask

  task automatic test_mode_lock();
    mode_btn = 1; cyc(); mode_btn = 0; cyc();
    total++; if (sel !== 1'b1) begin
      bad++; $display("FAIL lock_pause sel=%b want 1", sel);
    end
    start = 1; cyc(); start = 0;
    mode_btn = 1; cyc(); mode_btn = 0; cyc();
    total++; if (sel !== 1'b1 || running !== 1'b1) begin
      bad++; $display("FAIL lock_run sel=%b run=%b want 1/1", sel, running);
    end
    clear = 1; load_val = 8'd0; cyc(); clear = 0;
    start = 1; cyc(); start = 0;
    total++; if (done !== 1'b1 || running !== 1'b0 || down_count !== 8'd0) begin
      bad++; $display("FAIL zero_load done=%b run=%b down=%0d want 1/0/0", done, running, down_count);
    end
    mode_btn = 1; cyc();
    total++; if (sel !== 1'b1) begin
      bad++; $display("FAIL lock_done sel=%b want 1", sel);
    end
    clear = 1; cyc(); clear = 0;   // button still held into IDLE
    cyc(2);
    total++; if (sel !== 1'b1) begin
      bad++; $display("FAIL held_btn sel=%b want 1", sel);
    end
    mode_btn = 0; cyc(); mode_btn = 1; cyc();
    total++; if (sel !== 1'b0) begin
      bad++; $display("FAIL fresh_edge sel=%b want 0", sel);
    end
    mode_btn = 0; cyc(); mode_btn = 1; cyc();
    mode_btn = 0; cyc(); mode_btn = 1; cyc(); mode_btn = 0;
    total++; if (sel !== 1'b0) begin
      bad++; $display("FAIL two_rises sel=%b want 0", sel);
    end
  endtask

  task automatic test_priority();
    start = 1; stop = 1; clear = 1; load_val = 8'd9; cyc();
    start = 0; stop = 0; clear = 0;
    total++; if (running !== 1'b0 || done !== 1'b0 || down_count !== 8'd9) begin
      bad++; $display("FAIL all_three_idle run=%b done=%b down=%0d want 0/0/9", running, done, down_count);
    end
    start = 1; cyc(); start = 0;
    cyc(7);                        // up=1, prescaler 3
    clear = 1; load_val = 8'd5; cyc(); clear = 0;
    total++; if (up_count !== 8'd0 || running !== 1'b0 || down_count !== 8'd5) begin
      bad++; $display("FAIL tick_clear up=%0d run=%b down=%0d want 0/0/5", up_count, running, down_count);
    end
    start = 1; cyc(); start = 0; cyc(2);
    start = 1; stop = 1; clear = 1; load_val = 8'd7; cyc();
    start = 0; stop = 0; clear = 0;
    total++; if (running !== 1'b0 || up_count !== 8'd0 || down_count !== 8'd7) begin
      bad++; $display("FAIL all_three_run run=%b up=%0d down=%0d want 0/0/7", running, up_count, down_count);
    end
  endtask

  task automatic test_random();
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < 3000; i++) begin
      clear    = ($urandom_range(0, 99) < 3);
      stop     = ($urandom_range(0, 99) < 8);
      start    = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 99) < 20) mode_btn = ~mode_btn;
      load_val = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      cyc();
      total++;
      if (up_count !== 8'(m_up) || down_count !== 8'(m_down) || sel !== m_mode ||
          running !== (m_st == M_RUN) || done !== (m_st == M_DONE)) begin
        bad++;
        $display("FAIL random i=%0d up=%0d/%0d down=%0d/%0d sel=%b/%b run=%b/%b done=%b/%b (got/want)",
                 i, up_count, m_up, down_count, m_down, sel, m_mode,
                 running, (m_st == M_RUN), done, (m_st == M_DONE));
      end
    end
    start = 0; stop = 0; clear = 0; mode_btn = 0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_pause_resume();
    test_mode_lock();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
